// File: rtl/mem_pkg.sv
// Shared types and limits for the mem_responder bus target.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_e;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_BAD
    } mem_op_e;

    // Largest wait-state count the 4-bit wait counter can represent.
    localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word array: synchronous write, synchronous read into a cleared output register.
// Latency: read data appears one clk after re; write lands at the clk edge with we.
// Backpressure: none; the owner never asserts re and we together.
//
// Ports: clk, rst (sync, clears only the read register), re, we, addr, wdata, rdata.
module mem_resp_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    word_t mem [0:(2**DEPTH_LOG2)-1];

    // Array contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register is zero whenever no read was issued the cycle before,
    // so the owner can expose it directly as a bus output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM bus target answering mem_rd/mem_wr with a one-cycle ready (and err) strobe.
// Latency: ready WAIT_STATES+1 clks after the capture edge (1 clk for rd&wr); back-to-back every WAIT_STATES+2.
// Backpressure: requester holds strobes/addr/wr_data until it sees ready; inputs ignored in WAIT/RESP.
//
// Ports: clk, rst (sync, active-high), mem_rd, mem_wr, addr, wr_data -> rd_data, oe_rd_data, ready, err.
// Build option: define MEM_RESP_PROT_EN to make in-window writes below BASE_ADDR+PROT_LIMIT fail with err.
module mem_responder
    import mem_pkg::*;
#(
    parameter word_t BASE_ADDR   = 32'h0000_0000,
    parameter int    DEPTH_LOG2  = 12,
    parameter int    WAIT_STATES = 1,
    parameter word_t PROT_LIMIT  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        oe_rd_data,
    output logic        ready,
    output logic        err
);

    localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] WS_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    // Window size kept 33 bits wide so the top edge never wraps.
    localparam logic [32:0] WIN_WORDS = 33'd1 << DEPTH_LOG2;

    mem_resp_state_e        state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;

    // Captured request.
    mem_op_e                op_q;
    logic [DEPTH_LOG2-1:0]  off_q;
    word_t                  wdata_q;
    logic                   in_win_q;
    logic                   prot_q;

    // Live decode of the bus inputs.
    word_t                  live_diff;
    logic                   live_in_win;
    logic                   live_prot;
    mem_op_e                live_op;

    // Request in effect: live in IDLE, captured otherwise.
    mem_op_e                cur_op;
    logic [DEPTH_LOG2-1:0]  cur_off;
    logic                   cur_in_win;
    logic                   cur_prot;
    logic                   resp_err;

    logic                   ready_nxt, err_nxt, ram_re, ram_we;

    assign live_diff   = addr - BASE_ADDR;
    assign live_in_win = (addr >= BASE_ADDR) && ({1'b0, live_diff} < WIN_WORDS);

`ifdef MEM_RESP_PROT_EN
    assign live_prot = (live_diff < PROT_LIMIT);
`else
    // Protection compiled out: always false, limit referenced only to keep the parameter live.
    assign live_prot = 1'b0 & (live_diff < PROT_LIMIT);
`endif

    always_comb begin
        live_op = OP_RD;
        if (mem_rd && mem_wr) begin
            live_op = OP_BAD;
        end else if (mem_wr) begin
            live_op = OP_WR;
        end
    end

    assign cur_op     = (state == IDLE) ? live_op                         : op_q;
    assign cur_off    = (state == IDLE) ? live_diff[DEPTH_LOG2-1:0]       : off_q;
    assign cur_in_win = (state == IDLE) ? live_in_win                     : in_win_q;
    assign cur_prot   = (state == IDLE) ? live_prot                       : prot_q;

    assign resp_err = (cur_op == OP_BAD) || !cur_in_win ||
                      ((cur_op == OP_WR) && cur_prot);

    // State register, wait counter, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= OP_RD;
            off_q      <= '0;
            wdata_q    <= '0;
            in_win_q   <= 1'b0;
            prot_q     <= 1'b0;
            ready      <= 1'b0;
            err        <= 1'b0;
            oe_rd_data <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ready      <= ready_nxt;
            err        <= err_nxt;
            oe_rd_data <= ram_re;
            if ((state == IDLE) && (mem_rd || mem_wr)) begin
                op_q     <= live_op;
                off_q    <= live_diff[DEPTH_LOG2-1:0];
                wdata_q  <= wr_data;
                in_win_q <= live_in_win;
                prot_q   <= live_prot;
            end
        end
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_rd && mem_wr) begin
                    // Malformed request: answer immediately, no wait states.
                    state_nxt = RESP;
                end else if (mem_rd || mem_wr) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WS_INIT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed for the RESP cycle and registered on entry, so the
    // RAM read is issued on the same edge and its register lines up with ready.
    always_comb begin
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        ram_re    = 1'b0;
        if (state_nxt == RESP) begin
            ready_nxt = 1'b1;
            err_nxt   = resp_err;
            ram_re    = (cur_op == OP_RD) && !resp_err;
        end
    end

    // Write commits at the end of RESP; err already encodes window/protection/bad-op,
    // and a reset in that cycle drops the write.
    assign ram_we = (state == RESP) && (op_q == OP_WR) && !err && !rst;

    mem_resp_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (cur_off),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder over four parameterisations sharing one clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_responder;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic        e;
        logic        oe;
        logic [31:0] d;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        mem_rd     [4];
    logic        mem_wr     [4];
    logic [31:0] addr       [4];
    logic [31:0] wr_data    [4];
    logic [31:0] rd_data    [4];
    logic        oe_rd_data [4];
    logic        ready      [4];
    logic        err        [4];

    int n_checks = 0;
    int n_fail   = 0;

    // 0: WAIT_STATES=0, base 0
    mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(12), .WAIT_STATES(0), .PROT_LIMIT(32'h0)) u_d0 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .addr(addr[0]), .wr_data(wr_data[0]),
        .rd_data(rd_data[0]), .oe_rd_data(oe_rd_data[0]), .ready(ready[0]), .err(err[0]));
    // 1: WAIT_STATES=1, base 0x1000
    mem_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH_LOG2(12), .WAIT_STATES(1), .PROT_LIMIT(32'h0)) u_d1 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .addr(addr[1]), .wr_data(wr_data[1]),
        .rd_data(rd_data[1]), .oe_rd_data(oe_rd_data[1]), .ready(ready[1]), .err(err[1]));
    // 2: WAIT_STATES=3, base 0
    mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(12), .WAIT_STATES(3), .PROT_LIMIT(32'h0)) u_d3 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd[2]), .mem_wr(mem_wr[2]), .addr(addr[2]), .wr_data(wr_data[2]),
        .rd_data(rd_data[2]), .oe_rd_data(oe_rd_data[2]), .ready(ready[2]), .err(err[2]));
    // 3: WAIT_STATES=1, base 0, protection limit 16 words
    mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(12), .WAIT_STATES(1), .PROT_LIMIT(32'd16)) u_dp (
        .clk(clk), .rst(rst), .mem_rd(mem_rd[3]), .mem_wr(mem_wr[3]), .addr(addr[3]), .wr_data(wr_data[3]),
        .rd_data(rd_data[3]), .oe_rd_data(oe_rd_data[3]), .ready(ready[3]), .err(err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Starts at a negedge with the target idle; returns at a negedge one cycle after ready.
    task automatic access(input int i, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic e, output logic oe,
                          output logic [31:0] d);
        lat = -1; e = 1'b0; oe = 1'b0; d = '0;
        mem_rd[i] = rd; mem_wr[i] = wr; addr[i] = a; wr_data[i] = wd;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ready[i] === 1'b1) begin
                lat = n; e = err[i]; oe = oe_rd_data[i]; d = rd_data[i];
                break;
            end
        end
        mem_rd[i] = 1'b0; mem_wr[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("dut%0d_ready_single_pulse", i), {31'b0, ready[i]}, 32'h0);
    endtask

    task automatic run_vec(input int i, input string nm, input vec_t v);
        int          lat;
        logic        e, oe;
        logic [31:0] d;
        access(i, v.rd, v.wr, v.a, v.wd, lat, e, oe, d);
        chk({nm, "_lat"},  32'(lat), 32'(v.lat));
        chk({nm, "_err"},  {31'b0, e},  {31'b0, v.e});
        chk({nm, "_oe"},   {31'b0, oe}, {31'b0, v.oe});
        chk({nm, "_data"}, d, v.d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [13];
        vec_t        v;
        logic [31:0] exp_b2b [3];
        int          k;
        logic        any_pulse;
        int          lat;
        logic        e, oe;
        logic [31:0] d;

        // Instance 1: WAIT_STATES=1, base 0x1000, window 0x1000..0x1FFF.
        //             rd    wr    addr          wdata         lat e     oe    rd_data
        vt[0]  = '{1'b0, 1'b1, 32'h0000_1005, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_1005, 32'h0,         2, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[2]  = '{1'b0, 1'b1, 32'h0000_1FFF, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_1FFF, 32'h0,         2, 1'b0, 1'b1, 32'hCAFE_F00D};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         2, 1'b1, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 1'b1, 32'h0000_0FFF, 32'h1111_1111, 2, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 32'h0000_0FFF, 32'h0,         2, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0A0A_0A0A, 2, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h5555_5555, 2, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         2, 1'b0, 1'b1, 32'h0A0A_0A0A};
        vt[10] = '{1'b1, 1'b1, 32'h0000_1005, 32'h0BAD_0BAD, 1, 1'b1, 1'b0, 32'h0};
        vt[11] = '{1'b1, 1'b0, 32'h0000_1005, 32'h0,         2, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[12] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         2, 1'b1, 1'b0, 32'h0};

        exp_b2b[0] = 32'h11; exp_b2b[1] = 32'h22; exp_b2b[2] = 32'h33;

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rd[i] = 1'b0; mem_wr[i] = 1'b0; addr[i] = '0; wr_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_ready%0d", i), {31'b0, ready[i]}, 32'h0);
            chk($sformatf("reset_err%0d", i),   {31'b0, err[i]},   32'h0);
            chk($sformatf("reset_oe%0d", i),    {31'b0, oe_rd_data[i]}, 32'h0);
            chk($sformatf("reset_rd_data%0d", i), rd_data[i], 32'h0);
        end

        for (int j = 0; j < 13; j++) begin
            run_vec(1, $sformatf("vec%0d", j), vt[j]);
        end

        // WAIT_STATES=0: preload, then back-to-back reads with the strobe held high.
        run_vec(0, "pre0", '{1'b0, 1'b1, 32'd0, 32'h11, 1, 1'b0, 1'b0, 32'h0});
        run_vec(0, "pre1", '{1'b0, 1'b1, 32'd1, 32'h22, 1, 1'b0, 1'b0, 32'h0});
        run_vec(0, "pre2", '{1'b0, 1'b1, 32'd2, 32'h33, 1, 1'b0, 1'b0, 32'h0});
        run_vec(0, "pre3", '{1'b0, 1'b1, 32'd3, 32'h44, 1, 1'b0, 1'b0, 32'h0});
        k = 0;
        mem_rd[0] = 1'b1; addr[0] = 32'd0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", n), {31'b0, ready[0]}, {31'b0, (n % 2 == 0)});
            if (ready[0] === 1'b1 && k < 3) begin
                chk($sformatf("b2b_data%0d", k), rd_data[0], exp_b2b[k]);
                chk($sformatf("b2b_oe%0d", k), {31'b0, oe_rd_data[0]}, 32'h1);
                k++;
                addr[0] = 32'(k);
                if (k == 3) mem_rd[0] = 1'b0;
            end
        end
        mem_rd[0] = 1'b0;

        // Simultaneous rd&wr at addr 3: immediate err, RAM untouched.
        run_vec(0, "rdwr3",    '{1'b1, 1'b1, 32'd3, 32'h9999_9999, 1, 1'b1, 1'b0, 32'h0});
        run_vec(0, "rdwr3_rb", '{1'b1, 1'b0, 32'd3, 32'h0,         1, 1'b0, 1'b1, 32'h44});

        // WAIT_STATES=3: reset in the middle of a write's wait period.
        run_vec(2, "ws3_pre", '{1'b0, 1'b1, 32'd7, 32'hAAAA, 4, 1'b0, 1'b0, 32'h0});
        mem_wr[2] = 1'b1; addr[2] = 32'd7; wr_data[2] = 32'h1234;
        @(negedge clk);
        rst = 1'b1;
        mem_wr[2] = 1'b0;
        any_pulse = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            rst = 1'b0;
            any_pulse = any_pulse | ready[2] | err[2];
        end
        chk("ws3_reset_no_pulse", {31'b0, any_pulse}, 32'h0);
        run_vec(2, "ws3_rb", '{1'b1, 1'b0, 32'd7, 32'h0, 4, 1'b0, 1'b1, 32'hAAAA});

        // Instance 3 carries PROT_LIMIT=16.
`ifdef MEM_RESP_PROT_EN
        run_vec(3, "prot_wr2", '{1'b0, 1'b1, 32'd2, 32'hFF, 2, 1'b1, 1'b0, 32'h0});
        access(3, 1'b1, 1'b0, 32'd2, 32'h0, lat, e, oe, d);
        chk("prot_rb2_err", {31'b0, e}, 32'h0);
        chk("prot_rb2_oe", {31'b0, oe}, 32'h1);
        n_checks++;
        if (d === 32'hFF) begin
            n_fail++;
            $display("FAIL prot_rb2_unchanged actual=%h required=not 000000ff", d);
        end
        run_vec(3, "prot_wr16", '{1'b0, 1'b1, 32'd16, 32'h16, 2, 1'b0, 1'b0, 32'h0});
        run_vec(3, "prot_rb16", '{1'b1, 1'b0, 32'd16, 32'h0,  2, 1'b0, 1'b1, 32'h16});
        run_vec(3, "prot_wr20", '{1'b0, 1'b1, 32'd20, 32'hFF, 2, 1'b0, 1'b0, 32'h0});
        run_vec(3, "prot_rb20", '{1'b1, 1'b0, 32'd20, 32'h0,  2, 1'b0, 1'b1, 32'hFF});
`else
        run_vec(3, "noprot_wr2", '{1'b0, 1'b1, 32'd2,  32'hFF, 2, 1'b0, 1'b0, 32'h0});
        run_vec(3, "noprot_rb2", '{1'b1, 1'b0, 32'd2,  32'h0,  2, 1'b0, 1'b1, 32'hFF});
        run_vec(3, "noprot_wr20", '{1'b0, 1'b1, 32'd20, 32'h20, 2, 1'b0, 1'b0, 32'h0});
        run_vec(3, "noprot_rb20", '{1'b1, 1'b0, 32'd20, 32'h0,  2, 1'b0, 1'b1, 32'h20});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
